// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: serial-frame receive controller driving an external sipo_reg.
// Detects a start bit, samples each bit at mid-period, strobes the shift
// register once per data bit, checks the stop bit and hands the assembled
// word to the consumer through a valid/ready holding register.
// Optional even-parity bit between data and stop: define SIPO_RX_PARITY_EN.
module sipo_rx_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic             sipo_shift_en,
  output logic             sipo_bit,
  input  logic [WIDTH-1:0] sipo_data,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  generate
    if (WIDTH < 4) begin : g_bad_width
      $error("sipo_rx_ctrl: WIDTH must be >= 4");
    end
    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
      $error("sipo_rx_ctrl: CLKS_PER_BIT must be >= 4 and even");
    end
  endgenerate

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rx_s_q, rx_s_d;
  logic [1:0]       fill_q, fill_d;   // marks when rx_s_q holds a real line sample
  logic             prev_q, prev_d;   // previous rx_s was a genuine high
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             shift_en_q, shift_en_d;
  logic             bit_q, bit_d;
  logic [WIDTH-1:0] fdata_q, fdata_d;
  logic             fvalid_q, fvalid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             parity_bad;

`ifdef SIPO_RX_PARITY_EN
  logic par_q, par_d;
  assign parity_bad = (^sipo_data) ^ par_q;
`else
  assign parity_bad = 1'b0;
`endif

  // Next-state: synchronizer, bit timing FSM, holding register and handshake
  always_comb begin
    sync1_d    = rx_in;
    rx_s_d     = sync1_q;
    fill_d     = {fill_q[0], 1'b1};
    // Reset values of the synchronizer look like a high line; only arm on real samples
    prev_d     = fill_q[1] & rx_s_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_en_d = 1'b0;
    bit_d      = bit_q;
    fdata_d    = fdata_q;
    fvalid_d   = fvalid_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
`ifdef SIPO_RX_PARITY_EN
    par_d      = par_q;
`endif
    if (fvalid_q && frame_ready) fvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (prev_q && !rx_s_q) begin
          cnt_d   = HALF_M1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (rx_s_q) state_d = S_IDLE;      // glitch, not a start bit
        else begin
          cnt_d   = FULL_M1;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          shift_en_d = 1'b1;
          bit_d      = rx_s_q;
          idx_d      = idx_q + 1'b1;
          cnt_d      = FULL_M1;
`ifdef SIPO_RX_PARITY_EN
          if (idx_q == LAST_IDX) state_d = S_PARITY;
`else
          if (idx_q == LAST_IDX) state_d = S_STOP;
`endif
        end
      end
`ifdef SIPO_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          par_d   = rx_s_q;
          cnt_d   = FULL_M1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          fdata_d  = sipo_data;
          fvalid_d = 1'b1;
          ferr_d   = ~rx_s_q | parity_bad;
          // Same-cycle transfer frees the slot, so only an unaccepted frame overruns
          if (fvalid_q && !frame_ready) ovr_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      fill_q     <= '0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_en_q <= 1'b0;
      bit_q      <= 1'b0;
      fdata_q    <= '0;
      fvalid_q   <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      fill_q     <= fill_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_en_q <= shift_en_d;
      bit_q      <= bit_d;
      fdata_q    <= fdata_d;
      fvalid_q   <= fvalid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
`ifdef SIPO_RX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign sipo_shift_en = shift_en_q;
  assign sipo_bit      = bit_q;
  assign frame_data    = fdata_q;
  assign frame_valid   = fvalid_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Scoreboard bench for sipo_rx_ctrl: stimulus pushes expected bits/frames,
// a negedge monitor pops and compares on each shift strobe and frame load.
module tb_sipo_rx_ctrl;
  localparam int W = 8;
  localparam int C = 16;
`ifdef SIPO_RX_PARITY_EN
  localparam int LOAD_GAP = 2 * C;
`else
  localparam int LOAD_GAP = C;
`endif

  logic         clk = 1'b0;
  logic         rst, rx_in, frame_ready;
  logic         sipo_shift_en, sipo_bit, frame_valid, frame_err, overrun, busy;
  logic [W-1:0] sipo_data, frame_data;
  logic [W-1:0] sreg = '0;

  typedef struct packed {logic [W-1:0] data; logic err; logic ovr;} frm_t;
  frm_t exp_q[$];
  logic exp_bits[$];
  frm_t mon_e;
  int   vec_cnt = 0, miss_cnt = 0;
  int   cyc = 0, shift_total = 0, frame_shifts = 0, last_shift = 0;
  logic busy_d1 = 1'b0;
`ifdef SIPO_RX_PARITY_EN
  logic tx_par = 1'b0;
`endif

  sipo_rx_ctrl #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in),
    .sipo_shift_en(sipo_shift_en), .sipo_bit(sipo_bit), .sipo_data(sipo_data),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external shift register model, MSB-first
  always @(posedge clk) if (sipo_shift_en) sreg <= {sreg[W-2:0], sipo_bit};
  assign sipo_data = sreg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: shift strobes and frame loads
  always @(negedge clk) begin
    if (sipo_shift_en) begin
      shift_total++;
      if (exp_bits.size() == 0) chk("unexpected_shift", 1, 0);
      else chk("sipo_bit", sipo_bit, exp_bits.pop_front());
      if (frame_shifts > 0) chk("shift_spacing", cyc - last_shift, C);
      frame_shifts++;
      last_shift = cyc;
    end
    if (busy_d1 && !busy) begin
      if (frame_valid) begin
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("frame_data", frame_data, mon_e.data);
          chk("frame_err", frame_err, mon_e.err);
          chk("overrun", overrun, mon_e.ovr);
          chk("load_latency", cyc - last_shift, LOAD_GAP);
          chk("shift_count", frame_shifts, W);
        end
      end
      frame_shifts = 0;
    end
    busy_d1 = busy;
  end

  task automatic line_bits(input logic b, input int n);
    rx_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop_b);
    line_bits(1'b0, C);
    for (int i = W - 1; i >= 0; i--) line_bits(d[i], C);
`ifdef SIPO_RX_PARITY_EN
    line_bits(tx_par, C);
`endif
    line_bits(stop_b, C);
  endtask

  task automatic push_frame(input logic [W-1:0] d, input logic err, input logic ovr);
    frm_t f;
    f.data = d; f.err = err; f.ovr = ovr;
    exp_q.push_back(f);
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(d[i]);
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    chk("valid_clear", frame_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_shift"}, sipo_shift_en, 0);
    chk({tag, "_bit"}, sipo_bit, 0);
    chk({tag, "_data"}, frame_data, 0);
    chk({tag, "_valid"}, frame_valid, 0);
    chk({tag, "_err"}, frame_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int s;
    rst = 1'b1; rx_in = 1'b1; frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    line_bits(1'b1, 2 * C);

    // single frame 0xA5
    push_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1);
    line_bits(1'b1, C);
    chk("a5_valid", frame_valid, 1);
    consume();

    // false start: 4-cycle glitch
    s = shift_total;
    line_bits(1'b0, 4);
    line_bits(1'b1, 2 * C);
    chk("fs_shifts", shift_total - s, 0);
    chk("fs_valid", frame_valid, 0);
    chk("fs_busy", busy, 0);

    // bad stop bit, line then held low: no retrigger
    push_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0);
    s = shift_total;
    line_bits(1'b0, 3 * C);
    chk("bs_busy", busy, 0);
    chk("bs_shifts", shift_total - s, 0);
    chk("bs_err", frame_err, 1);
    consume();
    line_bits(1'b1, 2 * C);

    // same-cycle load and transfer on frame 2
    push_frame(8'h11, 1'b0, 1'b0);
    push_frame(8'h22, 1'b0, 1'b0);
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        int n, t;
        n = 0; t = 0;
        while (n < 2 * W && t < 40 * C) begin
          @(negedge clk);
          t++;
          if (sipo_shift_en) n++;
        end
        if (n < 2 * W) chk("sl_shift_timeout", n, 2 * W);
        else begin
          repeat (C - 1) @(posedge clk);
          #1 frame_ready = 1'b1;
          @(posedge clk);
          #1 frame_ready = 1'b0;
        end
      end
    join
    line_bits(1'b1, C);
    chk("sl_valid", frame_valid, 1);
    chk("sl_data", frame_data, 8'h22);
    chk("sl_ovr", overrun, 0);
    consume();

    // overrun: two frames, no ready
    push_frame(8'h11, 1'b0, 1'b0);
    push_frame(8'h22, 1'b0, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    line_bits(1'b1, C);
    chk("or_data", frame_data, 8'h22);
    chk("or_ovr", overrun, 1);
    consume();

    // reset after the 3rd shift of 0xFF, then 0x5A
    for (int i = 0; i < 3; i++) exp_bits.push_back(1'b1);
    line_bits(1'b0, C);
    line_bits(1'b1, 3 * C);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("mid");
    rst = 1'b0;
    line_bits(1'b1, 2 * C);
    push_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1);
    line_bits(1'b1, C);
    chk("5a_valid", frame_valid, 1);
    consume();

`ifdef SIPO_RX_PARITY_EN
    // even parity on 0x07
    tx_par = 1'b1;
    push_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1);
    line_bits(1'b1, C);
    consume();
    tx_par = 1'b0;
    push_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1);
    line_bits(1'b1, C);
    consume();
`endif

    chk("frames_left", exp_q.size(), 0);
    chk("bits_left", exp_bits.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
